// File: rtl/net_ctrl_pkg.sv
// Shared constants and state encoding for the layer-chain run controllers.
package net_ctrl_pkg;

  localparam int unsigned LAYER_IDX_W = 8;
  localparam int unsigned CYCLE_CNT_W = 32;

  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StIdle  = 3'd1,
    StRun   = 3'd2,
    StGap   = 3'd3,
    StDone  = 3'd4,
    StError = 3'd5
  } seq_state_e;

  function automatic logic [CYCLE_CNT_W-1:0] sat_inc(input logic [CYCLE_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Saturating cycle watchdog; expired is a registered compare against TIMEOUT_CYCLES-1.
module seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES >= 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      expired <= !clear && (cnt_d == Limit);
    end
  end

endmodule

// File: rtl/net_layer_sequencer.sv
// Run controller for the conv/pool layer chain: init wait, one layer at a time,
// ping-pong buffer toggling and a per-layer watchdog. No datapath.
module net_layer_sequencer
  import net_ctrl_pkg::*;
#(
  parameter int unsigned LAYER_NUM        = 3,
  parameter int unsigned INIT_WAIT_CYCLES = 128,
  parameter int unsigned GAP_CYCLES       = 2,
  parameter int unsigned TIMEOUT_CYCLES   = 65536
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [LAYER_NUM-1:0]   layer_finished,
  output logic [LAYER_NUM-1:0]   layer_en,
  output logic                   buf_sel,
  output logic [LAYER_IDX_W-1:0] cur_layer,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [LAYER_IDX_W-1:0] err_layer,
  output logic [CYCLE_CNT_W-1:0] run_cycles
);

  localparam int unsigned InitW = $clog2(INIT_WAIT_CYCLES + 1);
  localparam int unsigned GapW  = $clog2(GAP_CYCLES + 1);
  localparam logic [InitW-1:0]       InitLast  = InitW'(INIT_WAIT_CYCLES - 1);
  localparam logic [GapW-1:0]        GapLast   = GapW'(GAP_CYCLES - 1);
  localparam logic [LAYER_IDX_W-1:0] LastLayer = LAYER_IDX_W'(LAYER_NUM - 1);

  seq_state_e             state_q;
  logic [InitW-1:0]       init_cnt_q;
  logic [GapW-1:0]        gap_cnt_q;
  logic [CYCLE_CNT_W-1:0] run_cnt_q;

  logic fin_active, wd_clear, wd_count_en, wd_expired;

  // layer_en is one-hot on cur_layer in RUN, so this ignores inactive finish pulses.
  assign fin_active  = |(layer_finished & layer_en);
  assign wd_count_en = (state_q == StRun);
  assign wd_clear    = !abort && (((state_q == StIdle) && start) ||
                                  ((state_q == StGap) && (gap_cnt_q == GapLast)));

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      gap_cnt_q  <= '0;
      run_cnt_q  <= '0;
      layer_en   <= '0;
      buf_sel    <= 1'b0;
      cur_layer  <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_layer  <= '0;
      run_cycles <= '0;
    end else begin
      done <= 1'b0;
      if (abort && (state_q inside {StRun, StGap, StDone, StError})) begin
        // Abort leaves buf_sel and run_cycles as they were.
        state_q  <= StIdle;
        layer_en <= '0;
        error    <= 1'b0;
        busy     <= 1'b0;
        ready    <= 1'b1;
      end else begin
        unique case (state_q)
          StInit: begin
            if (init_cnt_q == InitLast) begin
              state_q <= StIdle;
              ready   <= 1'b1;
            end else begin
              init_cnt_q <= init_cnt_q + 1'b1;
            end
          end
          StIdle: begin
            if (start && !abort) begin
              state_q   <= StRun;
              layer_en  <= LAYER_NUM'(1);
              cur_layer <= '0;
              buf_sel   <= 1'b0;
              run_cnt_q <= '0;
              busy      <= 1'b1;
              ready     <= 1'b0;
            end
          end
          StRun: begin
            run_cnt_q <= sat_inc(run_cnt_q);
            if (fin_active) begin
              layer_en <= '0;
              buf_sel  <= ~buf_sel;
              if (cur_layer == LastLayer) begin
                state_q    <= StDone;
                done       <= 1'b1;
                busy       <= 1'b0;
                run_cycles <= sat_inc(run_cnt_q);
              end else begin
                state_q   <= StGap;
                gap_cnt_q <= '0;
              end
            end else if (wd_expired) begin
              state_q   <= StError;
              layer_en  <= '0;
              error     <= 1'b1;
              err_layer <= cur_layer;
              busy      <= 1'b0;
            end
          end
          StGap: begin
            run_cnt_q <= sat_inc(run_cnt_q);
            if (gap_cnt_q == GapLast) begin
              state_q   <= StRun;
              cur_layer <= cur_layer + 1'b1;
              layer_en  <= LAYER_NUM'(1) << (cur_layer + 1'b1);
            end else begin
              gap_cnt_q <= gap_cnt_q + 1'b1;
            end
          end
          StDone: begin
            state_q <= StIdle;
            ready   <= 1'b1;
          end
          StError: ;
          default: state_q <= StInit;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_net_layer_sequencer.sv
// Randomized bench for net_layer_sequencer against a trace-level reference model.
module tb_net_layer_sequencer;
  import net_ctrl_pkg::*;

  localparam int unsigned L     = 3;
  localparam int unsigned INIT  = 128;
  localparam int unsigned GAP   = 2;
  localparam int unsigned TO_WD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic sel = 1'b0;
  logic [L-1:0] fin = '0;

  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int lat_cfg[L];
  int last_rc = 0;

  logic start0, start1, abort0, abort1;
  logic [L-1:0] fin0, fin1, en0, en1, o_en;
  logic buf0, buf1, o_buf_sel, rdy0, rdy1, o_ready, bsy0, bsy1, o_busy;
  logic dn0, dn1, o_done, er0, er1, o_error;
  logic [LAYER_IDX_W-1:0] cl0, cl1, o_cur_layer, el0, el1, o_err_layer;
  logic [CYCLE_CNT_W-1:0] rc0, rc1, o_run_cycles;

  assign start0 = start & ~sel;
  assign start1 = start & sel;
  assign abort0 = abort & ~sel;
  assign abort1 = abort & sel;
  assign fin0 = sel ? '0 : fin;
  assign fin1 = sel ? fin : '0;
  assign o_en = sel ? en1 : en0;
  assign o_buf_sel = sel ? buf1 : buf0;
  assign o_ready = sel ? rdy1 : rdy0;
  assign o_busy = sel ? bsy1 : bsy0;
  assign o_done = sel ? dn1 : dn0;
  assign o_error = sel ? er1 : er0;
  assign o_cur_layer = sel ? cl1 : cl0;
  assign o_err_layer = sel ? el1 : el0;
  assign o_run_cycles = sel ? rc1 : rc0;

  net_layer_sequencer #(
    .LAYER_NUM(L), .INIT_WAIT_CYCLES(INIT), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(65536)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .layer_finished(fin0),
    .layer_en(en0), .buf_sel(buf0), .cur_layer(cl0), .ready(rdy0), .busy(bsy0),
    .done(dn0), .error(er0), .err_layer(el0), .run_cycles(rc0)
  );

  net_layer_sequencer #(
    .LAYER_NUM(L), .INIT_WAIT_CYCLES(INIT), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO_WD)
  ) dut_wd (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .layer_finished(fin1),
    .layer_en(en1), .buf_sel(buf1), .cur_layer(cl1), .ready(rdy1), .busy(bsy1),
    .done(dn1), .error(er1), .err_layer(el1), .run_cycles(rc1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [L-1:0] v);
    for (int i = 0; i < L; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [L-1:0] rot(input logic [L-1:0] v);
    return {v[L-2:0], v[L-1]};
  endfunction

  // Expects rst_n released just before; ready must appear after exactly INIT edges.
  task automatic init_wait();
    for (int k = 1; k <= INIT; k++) begin
      step();
      check_eq($sformatf("init_ready@%0d", k), 32'(o_ready), 32'(k >= INIT));
      check_eq($sformatf("init_en@%0d", k), 32'(o_en), 32'(0));
    end
  endtask

  // Runs one sequence with a reactive layer model; ab_layer<0 means no abort.
  task automatic run_seq(input int ab_layer, input int ab_age, input bit spur);
    logic [L:0] trace[$];
    logic [L:0] exp_tr[$];
    int n, age, done_cnt, ab_n, exp_rc, toggles, lim;
    bit stop;
    exp_rc = (L - 1) * GAP;
    for (int i = 0; i < L; i++) begin
      exp_rc += lat_cfg[i];
      for (int k = 0; k < lat_cfg[i]; k++) exp_tr.push_back({1'(i % 2), L'(1 << i)});
      if (i < L - 1) for (int k = 0; k < GAP; k++) exp_tr.push_back({1'((i + 1) % 2), L'(0)});
    end
    exp_tr.push_back({1'(L % 2), L'(0)});
    ab_n = -1;
    if (ab_layer >= 0) begin
      ab_n = ab_age;
      for (int i = 0; i < ab_layer; i++) ab_n += lat_cfg[i] + GAP;
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0; age = 0; done_cnt = 0; stop = 1'b0;
    while (!stop && n < 2000) begin
      if (n == ab_n) begin
        check_eq("abort_en", 32'(o_en), 32'(0));
        check_eq("abort_busy", 32'(o_busy), 32'(0));
        check_eq("abort_done", 32'(o_done), 32'(0));
        check_eq("abort_ready", 32'(o_ready), 32'(1));
        check_eq("abort_buf_sel", 32'(o_buf_sel), 32'(exp_tr[ab_n-1][L]));
        check_eq("abort_run_cycles", o_run_cycles, 32'(last_rc));
        stop = 1'b1;
      end else begin
        trace.push_back({o_buf_sel, o_en});
        if (o_done) begin
          done_cnt++;
          stop = 1'b1;
          check_eq("done_time", 32'(n), 32'(exp_rc));
          check_eq("run_cycles", o_run_cycles, 32'(exp_rc));
          check_eq("done_busy", 32'(o_busy), 32'(0));
          check_eq("final_cur_layer", 32'(o_cur_layer), 32'(L - 1));
        end
        age = (o_en != '0) ? age + 1 : 0;
        fin = '0;
        if (o_en != '0 && age == lat_cfg[onehot_idx(o_en)]) fin = o_en;
        if (spur && age == 2) fin = fin | rot(o_en);
        if (ab_n > 0 && n == ab_n - 1) begin
          abort = 1'b1;
          fin = o_en;
        end
        step();
        fin = '0;
        abort = 1'b0;
        n++;
      end
    end
    check_eq("run_terminated", 32'(stop), 32'(1));
    lim = (ab_n >= 0) ? ab_n : exp_tr.size();
    check_eq("trace_len", 32'(trace.size()), 32'(lim));
    for (int j = 0; j < lim && j < trace.size(); j++) begin
      check_eq($sformatf("trace[%0d]", j), 32'(trace[j]), 32'(exp_tr[j]));
      if (trace[j] !== exp_tr[j]) break;
    end
    if (ab_n < 0) begin
      toggles = 0;
      for (int j = 1; j < trace.size(); j++) if (trace[j][L] != trace[j-1][L]) toggles++;
      check_eq("buf_toggles", 32'(toggles), 32'(L));
      step();
      check_eq("post_done", 32'(o_done), 32'(0));
      check_eq("done_count", 32'(done_cnt), 32'(1));
      check_eq("post_ready", 32'(o_ready), 32'(1));
      check_eq("post_buf_sel", 32'(o_buf_sel), 32'(L % 2));
      check_eq("post_error", 32'(o_error), 32'(0));
      if (!sel) last_rc = exp_rc;
    end
  endtask

  initial begin
    int n;
    bit seen2;
    // 1: start held through reset and init; honoured only after ready rises.
    start = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    init_wait();
    step();
    check_eq("t1_en_after_init", 32'(o_en), 32'(1));
    check_eq("t1_busy", 32'(o_busy), 32'(1));
    check_eq("t1_ready", 32'(o_ready), 32'(0));
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("t1_abort_en", 32'(o_en), 32'(0));
    check_eq("t1_abort_ready", 32'(o_ready), 32'(1));

    // 2: fixed 50-cycle layers, then randomized latencies with stray finish pulses.
    for (int i = 0; i < L; i++) lat_cfg[i] = 50;
    run_seq(-1, 0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < L; i++) lat_cfg[i] = int'($urandom_range(4, 80));
      run_seq(-1, 0, 1'b1);
    end

    // 3: stray finish on layer 2, then abort together with layer 1's finish.
    lat_cfg[0] = 30; lat_cfg[1] = 60; lat_cfg[2] = 30;
    run_seq(1, int'($urandom_range(5, 40)), 1'b1);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_eq("t3_abort_beats_start", 32'(o_busy), 32'(0));

    // 4: watchdog expiry on layer 0.
    sel = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("t4_en0", 32'(o_en), 32'(1));
    n = 0;
    while (!o_error && n < 100) begin
      step();
      n++;
    end
    check_eq("t4_err_time", 32'(n), 32'(TO_WD));
    check_eq("t4_err_layer", 32'(o_err_layer), 32'(0));
    check_eq("t4_err_en", 32'(o_en), 32'(0));
    check_eq("t4_err_busy", 32'(o_busy), 32'(0));
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check_eq("t4_start_ignored", 32'(o_error), 32'(1));
    check_eq("t4_start_ignored_en", 32'(o_en), 32'(0));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("t4_abort_error", 32'(o_error), 32'(0));
    check_eq("t4_abort_ready", 32'(o_ready), 32'(1));

    // 5: finish lands in the expiry cycle and must win.
    lat_cfg[0] = TO_WD;
    lat_cfg[1] = int'($urandom_range(3, TO_WD - 1));
    lat_cfg[2] = TO_WD;
    run_seq(-1, 0, 1'b0);

    // 6: reset during the gap after layer 1.
    sel = 1'b0;
    for (int i = 0; i < L; i++) lat_cfg[i] = 10;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0; seen2 = 1'b0;
    while (n < 500 && !(seen2 && o_en == '0)) begin
      if (o_en == L'(2)) seen2 = 1'b1;
      fin = (o_en != '0 && o_cur_layer < 2) ? o_en : '0;
      step();
      fin = '0;
      n++;
    end
    check_eq("t6_reached_gap", 32'(seen2), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_en", 32'(o_en), 32'(0));
    check_eq("t6_rst_misc", 32'({o_buf_sel, o_ready, o_busy, o_done, o_error}), 32'(0));
    check_eq("t6_rst_cur_layer", 32'(o_cur_layer), 32'(0));
    check_eq("t6_rst_err_layer", 32'(o_err_layer), 32'(0));
    check_eq("t6_rst_run_cycles", o_run_cycles, 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    init_wait();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/net_layer_sequencer.md
Name: net_layer_sequencer

Overview:
- Top-level run controller for the conv/pool layer chain (C1S2 → C3S4 → F5 style layers), each of which has a level `en` input and a 1-cycle `work_finished` pulse output.
- Waits out the layers' post-reset kernel-RAM load, then runs the layers strictly one at a time on a host `start` pulse.
- Toggles the ping-pong feature-map buffer select between layers and guards each layer with a watchdog.
- Sits between the host control interface and the layer instances; it carries no datapath.

Parameters:
- LAYER_NUM, 3: number of sequenced layers (1..8).
- INIT_WAIT_CYCLES, 128: cycles after reset before the first start is accepted; covers the 96-entry kernel load plus pipeline delay.
- GAP_CYCLES, 2: cycles all `layer_en` bits are held low between consecutive layers, so each layer clears its anchor/output counters (min 1).
- TIMEOUT_CYCLES, 65536: maximum cycles one layer may run before an error is flagged.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run request; honoured only when ready=1
- abort  in  1  one-cycle request to stop immediately and return to IDLE
- layer_finished  in  LAYER_NUM  work_finished pulses; bit i belongs to layer i
- layer_en  out  LAYER_NUM  level enable; at most one bit high
- buf_sel  out  1  ping-pong select; the active layer reads bank buf_sel and writes bank ~buf_sel
- cur_layer  out  8  index of the active or most recent layer
- ready  out  1  IDLE state and init wait complete
- busy  out  1  high in RUN and GAP
- done  out  1  one-cycle pulse at the end of a successful run
- error  out  1  high while in ERROR
- err_layer  out  8  layer index that timed out; valid while error=1
- run_cycles  out  32  cycle count of the last completed run, start to done

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state INIT, all outputs 0, init counter 0.
- All outputs are registered.
- INIT:
  - Counts INIT_WAIT_CYCLES cycles, then moves to IDLE. ready rises on the first IDLE cycle.
  - start and abort are ignored during INIT.
- IDLE:
  - start=1 at edge t moves to RUN. At t+1: layer_en[0]=1, cur_layer=0, buf_sel=0, run counter and watchdog cleared, busy=1, ready=0.
- RUN:
  - layer_en[cur_layer] stays high. The watchdog increments every cycle.
  - layer_finished[cur_layer]=1, not the last layer: next cycle layer_en=0, buf_sel toggles, state goes to GAP.
  - layer_finished[cur_layer]=1, last layer (cur_layer=LAYER_NUM-1): next cycle layer_en=0, buf_sel toggles, state goes to DONE.
  - layer_finished bits of non-active layers are ignored.
- GAP:
  - Lasts exactly GAP_CYCLES cycles with layer_en=0.
  - Then cur_layer increments, the watchdog clears, the state returns to RUN, and the new layer_en bit rises.
- DONE:
  - One cycle: done=1, run_cycles latched, busy=0.
  - Next cycle: IDLE, ready=1. buf_sel holds its final value until the next start.
- Watchdog:
  - In RUN, if the watchdog reaches TIMEOUT_CYCLES-1 and no finish pulse arrives that cycle, the next cycle enters ERROR.
  - In ERROR: layer_en=0, error=1, err_layer=cur_layer, busy=0.
  - ERROR is left only by abort, which goes to IDLE. start is ignored in ERROR.
- abort:
  - In RUN, GAP, DONE or ERROR: the next cycle is IDLE with layer_en=0, error=0, busy=0.
  - No done pulse; buf_sel and run_cycles are unchanged.
- Simultaneous events:
  - abort beats finish.
  - Finish beats watchdog expiry.
  - abort beats start in IDLE; start is dropped.
  - start while busy is ignored, not queued.
- Counter widths:
  - run_cycles saturates at 0xFFFFFFFF.
  - The watchdog counter is $clog2(TIMEOUT_CYCLES) bits wide.
- Reset mid-run: all layer_en bits drop asynchronously and the state returns to INIT, so the full init wait repeats.

Decomposition:
- Shared package net_ctrl_pkg:
  - state encoding INIT/IDLE/RUN/GAP/DONE/ERROR as a 3-bit localparam set;
  - LAYER_IDX_W = 8;
  - CYCLE_CNT_W = 32.
- One sub-module, seq_watchdog:
  - inputs clear and count_en;
  - output expired, a registered compare against TIMEOUT_CYCLES-1;
  - reused by future DMA controllers.

Test Plan:
1. Reset, then start held from cycle 0. Require: start ignored until cycle 128; ready rises at cycle 128.
2. Start in IDLE, each layer finishing 50 cycles after its en rises. Require, with LAYER_NUM=3 and GAP=2:
   - layer_en sequence 001/000/010/000/100;
   - buf_sel toggles 3 times and ends at 1;
   - done pulses once;
   - run_cycles = 3*50 + 2*2 + overhead, with the exact value checked.
3. During layer 1's run, pulse layer_finished[2]. Require no effect. Then pulse layer_finished[1] together with abort. Require IDLE next cycle, no done, buf_sel = 1.
4. TIMEOUT_CYCLES=16, layer 0 never finishes. Require error=1 and err_layer=0 at cycle 16 after en rose. Then start ignored; abort returns to IDLE with ready=1.
5. TIMEOUT_CYCLES=16, finish arrives in the expiry cycle. Require GAP, not ERROR.
6. Assert rst_n low while in GAP of layer 1. Require all outputs 0 immediately, then the full INIT wait again.
